// File: rtl/sample_demux_pkg.sv
// Shared definitions for the channel-tagged sample demultiplexer.
package sample_demux_pkg;

  // Controller states; encoding is fixed so status readers can decode it.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_ERROR   = 2'd2
  } state_e;

  // Input word layout: [15:0] sample, [18:16] channel, [31:19] reserved.
  localparam int SAMPLE_LSB = 0;
  localparam int CHAN_LSB   = 16;
  localparam int RSVD_LSB   = 19;
  localparam int CHAN_W     = 3;

  localparam int CHANNELS = 8;

  // Lane reset value: midscale reads as zero magnitude downstream.
  localparam logic [15:0] MIDSCALE = 16'h8000;

  // One-hot lane select for a channel number.
  function automatic logic [CHANNELS-1:0] chan_onehot(input logic [CHAN_W-1:0] chan);
    return {{(CHANNELS-1){1'b0}}, 1'b1} << chan;
  endfunction

endpackage

// File: rtl/sample_stale_timer.sv
// Per-channel idle counter: counts run cycles since the channel last updated
// and flags when the count reaches a non-zero limit.
module sample_stale_timer #(
  parameter int STALE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic [STALE_W-1:0] limit,
  output logic               hit
);

  logic [STALE_W-1:0] count_q;

  // Clear wins over counting; the count saturates so it can never wrap past the limit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (run && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A zero limit disables the check.
  assign hit = (limit != '0) && (count_q >= limit);

endmodule

// File: rtl/sample_channel_demux.sv
// Splits a stream of channel-tagged sample words into eight parallel
// value/strobe lanes, with frame counting, optional strict ordering and
// per-channel stale detection.
module sample_channel_demux #(
  parameter int CHANNELS = 8,
  parameter int DATA_W   = 16,
  parameter int STALE_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       strict_order,
  input  logic [STALE_W-1:0]         stale_limit,
  input  logic [31:0]                s_word,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [CHANNELS*DATA_W-1:0] value_in_concat,
  output logic [CHANNELS-1:0]        value_ready_concat,
  output logic [31:0]                frame_count,
  output logic                       running,
  output logic                       err_stale,
  output logic                       err_order,
  output logic                       err_malformed
);

  import sample_demux_pkg::*;

  state_e              state_q;
  logic [DATA_W-1:0]   lane_q [CHANNELS];
  logic [CHANNELS-1:0] strobe_q;
  logic [CHANNELS-1:0] seen_q, seen_d;
  logic [CHAN_W-1:0]   expected_q, expected_d;
  logic [31:0]         frame_q, frame_d;
  logic                err_stale_q, err_order_q, err_malformed_q;

  logic [CHAN_W-1:0]   chan;
  logic [DATA_W-1:0]   sample;
  logic [31-RSVD_LSB:0] rsvd;
  logic                is_running, enter_run, accept;
  logic                bad_rsvd, bad_order, stale_err, any_err, good;
  logic [CHANNELS-1:0] good_hot, seen_merge, stale_hit;

  assign chan   = s_word[CHAN_LSB +: CHAN_W];
  assign sample = s_word[SAMPLE_LSB +: DATA_W];
  assign rsvd   = s_word[31:RSVD_LSB];

  assign is_running = (state_q == ST_RUNNING);
  assign enter_run  = (state_q == ST_IDLE) && enable;
  assign accept     = s_valid && is_running;

  // Error sources are evaluated independently so simultaneous errors all latch.
  assign bad_rsvd  = accept && (rsvd != '0);
  assign bad_order = accept && strict_order && (chan != expected_q);
  assign stale_err = is_running && (|stale_hit);
  assign any_err   = bad_rsvd || bad_order || stale_err;

  // Only a well-formed, in-order word touches a lane; stale errors do not drop it.
  assign good       = accept && !bad_rsvd && !bad_order;
  assign good_hot   = good ? chan_onehot(chan) : '0;
  assign seen_merge = seen_q | good_hot;

  // Next-state of frame tracking and order counter.
  always_comb begin
    seen_d     = seen_q;
    expected_d = expected_q;
    frame_d    = frame_q;
    if (enter_run) begin
      seen_d     = '0;
      expected_d = '0;
    end else if (good) begin
      expected_d = expected_q + 1'b1;
      if (seen_merge == '1) begin
        seen_d  = '0;
        frame_d = frame_q + 32'd1;
      end else begin
        seen_d = seen_merge;
      end
    end
  end

  // Controller FSM with sticky error flags; ERROR is left only through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      err_stale_q     <= 1'b0;
      err_order_q     <= 1'b0;
      err_malformed_q <= 1'b0;
    end else begin
      err_stale_q     <= err_stale_q     | stale_err;
      err_order_q     <= err_order_q     | bad_order;
      err_malformed_q <= err_malformed_q | bad_rsvd;
      case (state_q)
        ST_IDLE:    if (enable) state_q <= ST_RUNNING;
        ST_RUNNING: begin
          if (any_err)      state_q <= ST_ERROR;
          else if (!enable) state_q <= ST_IDLE;
        end
        ST_ERROR:   state_q <= ST_ERROR;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes, frame mask, order counter and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q   <= '0;
      seen_q     <= '0;
      expected_q <= '0;
      frame_q    <= '0;
    end else begin
      strobe_q   <= good_hot;
      seen_q     <= seen_d;
      expected_q <= expected_d;
      frame_q    <= frame_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      // Lane value holds the most recent good sample for its channel.
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_q[gi] <= MIDSCALE;
        end else if (good_hot[gi]) begin
          lane_q[gi] <= sample;
        end
      end

      assign value_in_concat[gi*DATA_W +: DATA_W] = lane_q[gi];

      sample_stale_timer #(
        .STALE_W(STALE_W)
      ) u_stale (
        .clk  (clk),
        .rst  (rst),
        .clear(enter_run || good_hot[gi]),
        .run  (is_running),
        .limit(stale_limit),
        .hit  (stale_hit[gi])
      );
    end
  endgenerate

  assign s_ready            = is_running;
  assign running            = is_running;
  assign value_ready_concat = strobe_q;
  assign frame_count        = frame_q;
  assign err_stale          = err_stale_q;
  assign err_order          = err_order_q;
  assign err_malformed      = err_malformed_q;

endmodule

// File: tb/tb_sample_channel_demux.sv
// Directed bench for sample_channel_demux: a scoreboard queue receives the
// expected lane/strobe/frame result for every good word driven, and a
// negedge monitor pops and compares whenever a strobe appears.
module tb_sample_channel_demux;

  localparam logic [127:0] MID_ALL = {8{16'h8000}};

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         strict_order;
  logic [15:0]  stale_limit;
  logic [31:0]  s_word;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] value_in_concat;
  logic [7:0]   value_ready_concat;
  logic [31:0]  frame_count;
  logic         running;
  logic         err_stale;
  logic         err_order;
  logic         err_malformed;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] val;
    logic [31:0] frame;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  seen_m;
  logic [31:0] frame_m;
  int          vectors    = 0;
  int          miscompares = 0;

  sample_channel_demux dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .strict_order      (strict_order),
    .stale_limit       (stale_limit),
    .s_word            (s_word),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .value_in_concat   (value_in_concat),
    .value_ready_concat(value_ready_concat),
    .frame_count       (frame_count),
    .running           (running),
    .err_stale         (err_stale),
    .err_order         (err_order),
    .err_malformed     (err_malformed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Queue the expected result of a good word, then present it for one edge.
  task automatic send_good(input int c, input logic [15:0] v);
    exp_t e;
    seen_m = seen_m | (8'b1 << c);
    if (seen_m == 8'hFF) begin
      frame_m = frame_m + 32'd1;
      seen_m  = 8'h00;
    end
    e.ch = 3'(c);
    e.val = v;
    e.frame = frame_m;
    sb.push_back(e);
    s_word  = {13'd0, 3'(c), v};
    s_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_m = 8'h00; frame_m = 32'd0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    @(posedge clk); #1;
    seen_m = 8'h00;
    chk("run_start", {s_ready, running}, 2'b11);
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (value_ready_concat !== 8'h00) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_strobe: observed %0h expected 0", value_ready_concat);
      end else begin
        exp_t e;
        logic [7:0] hot;
        e = sb.pop_front();
        hot = 8'b1 << e.ch;
        chk("strobe", value_ready_concat, hot);
        chk("lane_value", value_in_concat[e.ch*16 +: 16], e.val);
        chk("frame_count", frame_count, e.frame);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bit done;
    rst = 1'b1; enable = 1'b0; strict_order = 1'b0; stale_limit = 16'd0;
    s_word = 32'd0; s_valid = 1'b0;
    seen_m = 8'h00; frame_m = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_values", value_in_concat, MID_ALL);
    chk("rst_strobe", value_ready_concat, 8'h00);
    chk("rst_frame", frame_count, 32'd0);
    chk("rst_ready_run", {s_ready, running}, 2'b00);
    chk("rst_errors", {err_stale, err_order, err_malformed}, 3'b000);
    rst = 1'b0;
    #1;
    chk("idle_ready", s_ready, 1'b0);

    // Ordered stream, strict mode
    strict_order = 1'b1;
    start_run();
    for (int c = 0; c < 8; c++) send_good(c, 16'h1000 + 16'(c));
    idle(2);
    chk("ordered_frame", frame_count, 32'd1);
    chk("ordered_lanes", value_in_concat,
        {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000});
    chk("ordered_sb_empty", 32'(sb.size()), 32'd0);

    // Order violation
    do_reset();
    strict_order = 1'b1;
    start_run();
    send_good(0, 16'h2000);
    s_word = {13'd0, 3'd2, 16'h2222}; s_valid = 1'b1;
    @(posedge clk); #1;
    chk("order_err", {err_order, err_malformed, err_stale}, 3'b100);
    chk("order_ready", {s_ready, running}, 2'b00);
    s_word = {13'd0, 3'd1, 16'h2111};
    repeat (4) @(posedge clk);
    #1;
    chk("order_ready_hold", s_ready, 1'b0);
    chk("order_lane2", value_in_concat[47:32], 16'h8000);
    chk("order_lane1", value_in_concat[31:16], 16'h8000);
    idle(1);
    chk("order_sb_empty", 32'(sb.size()), 32'd0);

    // Malformed word
    do_reset();
    strict_order = 1'b0;
    start_run();
    s_word = 32'h0008_1234; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("malformed_err", {err_malformed, err_order, err_stale}, 3'b100);
    chk("malformed_state", {s_ready, running}, 2'b00);
    idle(2);
    chk("malformed_lanes", value_in_concat, MID_ALL);

    // Stale detection with limit 100, only channels 0..6 fed
    do_reset();
    strict_order = 1'b0;
    stale_limit = 16'd100;
    start_run();
    cyc = 0; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      send_good(k % 7, 16'h6000 + 16'(k));
      cyc++;
      if (err_stale) done = 1'b1;
    end
    s_valid = 1'b0;
    chk("stale_cycles", cyc, 101);
    chk("stale_state", {err_stale, err_order, err_malformed, running}, 4'b1000);
    idle(2);
    chk("stale_sb_empty", 32'(sb.size()), 32'd0);

    // Same stimulus with the stale check disabled
    do_reset();
    stale_limit = 16'd0;
    start_run();
    for (int k = 0; k < 150; k++) send_good(k % 7, 16'h7000 + 16'(k));
    idle(2);
    chk("nostale_state", {err_stale, running}, 2'b01);
    chk("nostale_frame", frame_count, 32'd0);

    // Duplicates in non-strict mode
    do_reset();
    start_run();
    send_good(3, 16'h003A);
    send_good(3, 16'h003B);
    send_good(0, 16'h0030);
    send_good(1, 16'h0031);
    send_good(2, 16'h0032);
    for (int c = 4; c < 7; c++) send_good(c, 16'h0030 + 16'(c));
    idle(1);
    chk("dup_frame_before", frame_count, 32'd0);
    send_good(7, 16'h0037);
    idle(2);
    chk("dup_frame", frame_count, 32'd1);
    chk("dup_lane3", value_in_concat[63:48], 16'h003B);

    // Enable drop mid-frame, then re-enable and send a full frame
    for (int c = 0; c < 3; c++) send_good(c, 16'h0040 + 16'(c));
    enable = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("drop_running", {s_ready, running}, 2'b00);
    idle(4);
    chk("drop_lanes_held", value_in_concat[47:0], {16'h0042, 16'h0041, 16'h0040});
    chk("drop_frame_held", frame_count, 32'd1);
    start_run();
    for (int c = 0; c < 8; c++) send_good(c, 16'h0050 + 16'(c));
    idle(2);
    chk("reenable_frame", frame_count, 32'd2);

    // Reset asserted during an accept
    s_word = {13'd0, 3'd5, 16'hDEAD}; s_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_values", value_in_concat, MID_ALL);
    chk("midrst_misc", {value_ready_concat, s_ready, running, err_stale, err_order, err_malformed}, 13'd0);
    chk("midrst_frame", frame_count, 32'd0);
    rst = 1'b0; s_valid = 1'b0; enable = 1'b0;
    idle(2);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
